// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver: filtered clock, frame decode, E0/F0 prefix merge.
// Optional macro PS2_RX_FIFO_EN selects a 4-deep event FIFO instead of a single holding register.
module ps2_scancode_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 2047
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] code,
  output logic       released,
  output logic       extended,
  output logic       err,
  output logic       overrun
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
  state_t r_state, w_state_next;

  logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FILTER-1:0] r_filt;
  logic              r_filt_clk;
  logic [TW-1:0]     r_to_cnt;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic              r_parity;
  logic              r_pend_ext, r_pend_rel;
  logic              r_err, r_overrun;

  logic [FILTER-1:0] w_filt_next;
  logic              w_fall, w_bit, w_timeout;
  logic              w_accept, w_reject, w_is_e0, w_is_f0, w_emit, w_pop;
  logic [9:0]        w_ev;

  assign w_filt_next = {r_filt[FILTER-2:0], r_clk_s2};
  assign w_fall      = ce && r_filt_clk && (w_filt_next == '0);
  assign w_bit       = r_dat_s2;
  assign w_timeout   = ce && (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_is_e0     = w_accept && (r_shift == 8'hE0);
  assign w_is_f0     = w_accept && (r_shift == 8'hF0);
  assign w_emit      = w_accept && !w_is_e0 && !w_is_f0;
  assign w_ev        = {r_pend_ext, r_pend_rel, r_shift};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2[0]; r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2[1]; r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock only changes once the whole sample window agrees.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_filt     <= '1;
      r_filt_clk <= 1'b1;
    end else if (ce) begin
      r_filt <= w_filt_next;
      if (w_filt_next == '1)      r_filt_clk <= 1'b1;
      else if (w_filt_next == '0) r_filt_clk <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_bit) w_state_next = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: w_state_next = S_STOP;
        S_STOP: begin
          w_state_next = S_IDLE;
          if (w_bit && (^r_shift ^ r_parity)) w_accept = 1'b1;
          else                                w_reject = 1'b1;
        end
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_to_cnt   <= '0;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_parity   <= 1'b0;
      r_pend_ext <= 1'b0;
      r_pend_rel <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_reject;
      if (ce) begin
        if (r_state == S_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
        else                                          r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= 3'd0;
          S_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_parity <= w_bit;
          default:  ;
        endcase
      end
      if (w_reject || w_emit) begin
        r_pend_ext <= 1'b0;
        r_pend_rel <= 1'b0;
      end else begin
        if (w_is_e0) r_pend_ext <= 1'b1;
        if (w_is_f0) r_pend_rel <= 1'b1;
      end
    end
  end

`ifdef PS2_RX_FIFO_EN
  logic [9:0] r_mem [4];
  logic [1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0] r_count;
  logic       w_push;

  assign w_pop  = (r_count != 3'd0) && ready;
  assign w_push = w_emit && ((r_count != 3'd4) || w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 10'h000;
      r_wr_ptr  <= 2'd0;
      r_rd_ptr  <= 2'd0;
      r_count   <= 3'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_ev;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_emit && !w_push) r_overrun <= 1'b1;
    end
  end

  assign valid                      = (r_count != 3'd0);
  assign {extended, released, code} = r_mem[r_rd_ptr];
`else
  logic       r_valid;
  logic [9:0] r_data;

  assign w_pop = r_valid && ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_data    <= 10'h000;
      r_overrun <= 1'b0;
    end else begin
      if (w_emit && (!r_valid || w_pop)) begin
        r_valid <= 1'b1;
        r_data  <= w_ev;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      if (w_emit && r_valid && !w_pop) r_overrun <= 1'b1;
    end
  end

  assign valid                      = r_valid;
  assign {extended, released, code} = r_data;
`endif

  assign err     = r_err;
  assign overrun = r_overrun;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - directed frame tests for ps2_scancode_rx.
// Honours PS2_RX_FIFO_EN when computing the overrun expectations.
module tb_ps2_scancode_rx;
  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic [1:0] ps2;
  logic       valid, ready, released, extended, err, overrun;
  logic [7:0] code;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  logic [9:0] evq [$];

  ps2_scancode_rx #(.FILTER(8), .TIMEOUT(2047)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2(ps2),
    .valid(valid), .ready(ready), .code(code),
    .released(released), .extended(extended),
    .err(err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (valid && ready) evq.push_back({extended, released, code});
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    ps2[1] = b;
    repeat (20) @(negedge clock);
    ps2[0] = 1'b0;
    repeat (20) @(negedge clock);
    ps2[0] = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~^d ^ bad_par);
    send_bit(1'b1);
    ps2 = 2'b11;
    repeat (30) @(negedge clock);
  endtask

  task automatic expect_one(input string tag, input logic [9:0] exp);
    logic [9:0] ev;
    check({tag, " count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      check({tag, " event"}, ev, exp);
    end
    evq.delete();
  endtask

  initial begin
    int e0;
    reset = 1'b1; ce = 1'b1; ps2 = 2'b11; ready = 1'b1;
    repeat (5) @(negedge clock);
    check("rst valid", valid, 0);
    check("rst code", code, 8'h00);
    check("rst released", released, 0);
    check("rst extended", extended, 0);
    check("rst err", err, 0);
    check("rst overrun", overrun, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    e0 = err_cnt;
    send_frame(8'h1C, 1'b0);
    expect_one("make 1C", {2'b00, 8'h1C});
    check("make 1C err", err_cnt - e0, 0);

    send_frame(8'hF0, 1'b0);
    check("F0 silent", evq.size(), 0);
    send_frame(8'h1C, 1'b0);
    expect_one("break 1C", {2'b01, 8'h1C});

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h6B, 1'b0);
    expect_one("ext break 6B", {2'b11, 8'h6B});
    send_frame(8'h29, 1'b0);
    expect_one("after ext 29", {2'b00, 8'h29});

    e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    check("bad parity err", err_cnt - e0, 1);
    check("bad parity no event", evq.size(), 0);
    send_frame(8'h1C, 1'b0);
    expect_one("recover 1C", {2'b00, 8'h1C});

    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2 = 2'b11;
    repeat (2100) @(negedge clock);
    send_frame(8'h45, 1'b0);
    expect_one("timeout 45", {2'b00, 8'h45});
    check("timeout err", err_cnt - e0, 0);

    ready = 1'b0;
    send_frame(8'h16, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'h26, 1'b0);
    send_frame(8'h25, 1'b0);
    send_frame(8'h2E, 1'b0);
    check("ovr flag", overrun, 1);
    check("ovr valid held", valid, 1);
    check("ovr code held", code, 8'h16);
    ready = 1'b1;
    repeat (10) @(negedge clock);
`ifdef PS2_RX_FIFO_EN
    check("fifo count", evq.size(), 4);
    if (evq.size() == 4) begin
      check("fifo 0", evq[0], {2'b00, 8'h16});
      check("fifo 1", evq[1], {2'b00, 8'h1E});
      check("fifo 2", evq[2], {2'b00, 8'h26});
      check("fifo 3", evq[3], {2'b00, 8'h25});
    end
`else
    check("reg count", evq.size(), 1);
    if (evq.size() == 1) check("reg 0", evq[0], {2'b00, 8'h16});
`endif
    evq.delete();
    check("ovr sticky", overrun, 1);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    ps2 = 2'b11;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midrst overrun", overrun, 0);
    check("midrst valid", valid, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    send_frame(8'h29, 1'b0);
    expect_one("after reset 29", {2'b00, 8'h29});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 Parameter FILTER, default 8: number of consecutive equal ce-samples that qualify a PS/2 clock level.
REQ-002 Parameter TIMEOUT, default 2047: number of ce cycles without a qualified falling edge that aborts a frame in progress.
REQ-003 Port clock  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port ce  input  1: sample enable for PS/2 line sampling, filter, frame and timeout logic.
REQ-006 Port ps2  input  2: ps2[0] is PS/2 clock, ps2[1] is PS/2 data; both are raw asynchronous inputs.
REQ-007 Port valid  output  1: a decoded key event is presented.
REQ-008 Port ready  input  1: consumer accepts the presented event.
REQ-009 Port code  output  8: scancode of the presented event.
REQ-010 Port released  output  1: the presented event was preceded by prefix F0.
REQ-011 Port extended  output  1: the presented event was preceded by prefix E0.
REQ-012 Port err  output  1: one-clock pulse on a parity or framing error.
REQ-013 Port overrun  output  1: sticky flag set when an event is dropped.

Function
REQ-014 ps2[0] and ps2[1] SHALL pass through a 2-flop synchronizer on every clock before any use.
REQ-015 The filtered PS/2 clock SHALL go high after FILTER consecutive high ce-samples and low after FILTER consecutive low ce-samples; otherwise it holds its value.
REQ-016 A qualified falling edge SHALL be a filtered high-to-low transition; data SHALL be the synchronized ps2[1] sampled on the same ce cycle.
REQ-017 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-018 IDLE -> DATA on an edge with data 0; an edge with data 1 in IDLE is ignored.
REQ-019 DATA SHALL shift 8 bits LSB first, then go to PARITY; PARITY SHALL latch the bit and go to STOP.
REQ-020 In STOP, a frame is accepted when stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity); the FSM returns to IDLE in every case.
REQ-021 A rejected frame SHALL pulse err for one clock, discard the byte, and clear both prefix flags.
REQ-022 In any state other than IDLE, a TIMEOUT-cycle gap between edges SHALL return the FSM to IDLE silently, with no err pulse and prefix flags retained.
REQ-023 Accepted byte E0 SHALL set the pending-extended flag; F0 SHALL set the pending-released flag; neither SHALL be emitted.
REQ-024 Any other accepted byte, including E1, SHALL be emitted as {extended, released, code} from the pending flags, and the pending flags SHALL then clear.
REQ-025 A handshake transfer SHALL occur on any clock where valid and ready are both 1, independent of ce.
REQ-026 An emitted event SHALL become visible on valid/code exactly one clock after the STOP-state edge when the output is empty.
REQ-027 An event that cannot be stored SHALL be dropped and set overrun; overrun SHALL clear only on reset.
REQ-028 Outputs code, released and extended SHALL be stable while valid=1 and ready=0.

Reset
REQ-029 Reset SHALL force: FSM IDLE, filter and filtered clock high, shift and timeout counters 0, prefix flags 0, storage empty.
REQ-030 Reset SHALL force the outputs valid=0, code=8'h00, released=0, extended=0, err=0, overrun=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait for the next start bit.

Configuration
REQ-032 Macro PS2_RX_FIFO_EN defined: events SHALL be held in a 4-entry, 10-bit FIFO; push and pop on the same clock while full SHALL be legal (pop first, push accepted); a push while full without a pop SHALL drop the event and set overrun.
REQ-033 Macro PS2_RX_FIFO_EN undefined: events SHALL be held in a single register; a new event arriving while valid=1 and not popped on that clock SHALL be dropped and set overrun.

Verification
REQ-034 Frame 0x1C, odd parity, ready=1 -> one valid beat: code=1C, released=0, extended=0, err=0.
REQ-035 Frames F0,1C -> a single event: code=1C, released=1; no event emitted for F0.
REQ-036 Frames E0,F0,6B -> a single event: code=6B, extended=1, released=1; the next frame 0x29 gives extended=0, released=0.
REQ-037 Frame 0x1C with parity bit inverted -> err pulses for one clock, no event; the following valid frame decodes normally.
REQ-038 Start bit and 4 data bits, then idle for more than TIMEOUT ce cycles, then a full frame 0x45 -> single event code=45, err=0.
REQ-039 ready=0 and 5 frames 16,1E,26,25,2E -> FIFO on: 16,1E,26,25 delivered in order, overrun=1; FIFO off: only 16 delivered, overrun=1.
